// File: rtl/ub_upsample_pingpong_if.sv
// Stream interface for ub_upsample_pingpong.
// Carries the input pixel handshake (in_valid/in_ready/in_data), the output
// pixel handshake (out_valid/out_ready/out_data) and the two frame-done
// pulses.
//   slave  : the buffer side (accepts input pixels, produces output pixels)
//   master : the surrounding pipeline / testbench side
interface ub_upsample_pingpong_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              wr_frame_done;
  logic              rd_frame_done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, wr_frame_done, rd_frame_done
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, wr_frame_done, rd_frame_done
  );
endinterface

// File: rtl/ub_upsample_pingpong.sv
// Ping-pong frame buffer with nearest-neighbour up-sampling.
// Stores IMG_W x IMG_H input frames in two banks. The writer fills the
// non-full bank in raster order; the reader drains the full bank, emitting
// an (IMG_W<<UP_SHIFT) x (IMG_H<<UP_SHIFT) raster in which every input pixel
// is replicated 2^UP_SHIFT times horizontally and vertically.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous clear (only when UB_FLUSH_EN is defined)
//   bus.slave    in_valid/in_ready/in_data      input pixel stream
//                out_valid/out_ready/out_data   up-sampled output stream
//                wr_frame_done                  last input pixel accepted
//                rd_frame_done                  last output pixel accepted
// Optional feature macro: UB_FLUSH_EN adds the flush port.
module ub_upsample_pingpong #(
  parameter int DATA_W   = 16,
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int UP_SHIFT = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef UB_FLUSH_EN
  input  logic flush,
`endif
  ub_upsample_pingpong_if.slave bus
);

  localparam int OUT_W  = IMG_W << UP_SHIFT;
  localparam int OUT_H  = IMG_H << UP_SHIFT;
  localparam int DEPTH  = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int WX_W   = $clog2(IMG_W);
  localparam int WY_W   = $clog2(IMG_H);
  localparam int OX_W   = $clog2(OUT_W);
  localparam int OY_W   = $clog2(OUT_H);

  localparam logic [WX_W-1:0]   WX_LAST = WX_W'(IMG_W - 1);
  localparam logic [WY_W-1:0]   WY_LAST = WY_W'(IMG_H - 1);
  localparam logic [OX_W-1:0]   OX_LAST = OX_W'(OUT_W - 1);
  localparam logic [OY_W-1:0]   OY_LAST = OY_W'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);

  logic [DATA_W-1:0] bank [2][DEPTH];

  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_sel;
  logic              rd_sel;
  logic [WX_W-1:0]   wx;
  logic [WY_W-1:0]   wy;
  logic [OX_W-1:0]   ox;
  logic [OY_W-1:0]   oy;

  logic              vld_p1;
  logic              last_p1;
  logic [DATA_W-1:0] data_p1;
  logic              wr_done;
  logic              rd_done;

  logic              clr;
  logic              in_ready_c;
  logic              wr_acc;
  logic              wr_last;
  logic              rd_fetch;
  logic              rd_last;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;

`ifdef UB_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // Writer only ever sees a non-full bank and the reader only a full one, so
  // both sides can move in the same cycle without touching the same bank.
  assign in_ready_c = ~full[wr_sel] & ~clr;
  assign wr_acc     = bus.in_valid & in_ready_c;
  assign wr_last    = (wx == WX_LAST) && (wy == WY_LAST);
  assign rd_fetch   = full[rd_sel] & (~vld_p1 | bus.out_ready) & ~clr;
  assign rd_last    = (ox == OX_LAST) && (oy == OY_LAST);

  assign waddr = ADDR_W'(wy) * ROW_STRIDE + ADDR_W'(wx);
  // Dropping the low UP_SHIFT bits of the output coordinates maps each
  // output pixel onto its source pixel.
  assign raddr = ADDR_W'(oy >> UP_SHIFT) * ROW_STRIDE + ADDR_W'(ox >> UP_SHIFT);

  // A bank filled and the other bank released in the same cycle both apply.
  always_comb begin
    full_nxt = full;
    if (wr_acc && wr_last) full_nxt[wr_sel] = 1'b1;
    if (rd_fetch && rd_last) full_nxt[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) bank[wr_sel][waddr] <= bus.in_data;
  end

  // Stage p0 -> p1: bank read into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 2'b00;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      wx      <= '0;
      wy      <= '0;
      ox      <= '0;
      oy      <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
    end else if (clr) begin
      full    <= 2'b00;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      wx      <= '0;
      wy      <= '0;
      ox      <= '0;
      oy      <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      full    <= full_nxt;
      wr_done <= wr_acc & wr_last;
      // last_p1 marks the registered pixel as the frame's final one, so the
      // pulse lands in the cycle after that pixel is taken.
      rd_done <= vld_p1 & bus.out_ready & last_p1;

      if (wr_acc) begin
        if (wx == WX_LAST) begin
          wx <= '0;
          wy <= (wy == WY_LAST) ? '0 : wy + 1'b1;
        end else begin
          wx <= wx + 1'b1;
        end
        if (wr_last) wr_sel <= ~wr_sel;
      end

      if (rd_fetch) begin
        data_p1 <= bank[rd_sel][raddr];
        vld_p1  <= 1'b1;
        last_p1 <= rd_last;
        if (ox == OX_LAST) begin
          ox <= '0;
          oy <= (oy == OY_LAST) ? '0 : oy + 1'b1;
        end else begin
          ox <= ox + 1'b1;
        end
        if (rd_last) rd_sel <= ~rd_sel;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = vld_p1 & ~clr;
  assign bus.out_data      = data_p1;
  assign bus.wr_frame_done = wr_done;
  assign bus.rd_frame_done = rd_done;

endmodule

// File: tb/tb_ub_upsample_pingpong.sv
// Testbench for ub_upsample_pingpong (IMG_W=IMG_H=4, UP_SHIFT=1).
// Expected output pixels are queued whenever a full input frame has been
// written and are popped by a monitor as the DUT hands out pixels.
module tb_ub_upsample_pingpong;
  localparam int DW   = 16;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int F    = 2;
  localparam int OW   = W * F;
  localparam int OH   = H * F;
  localparam int NPIX = W * H;
  localparam int TMO  = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef UB_FLUSH_EN
  logic flush = 1'b0;
`endif

  ub_upsample_pingpong_if #(.DATA_W(DW)) bus ();

  ub_upsample_pingpong #(
    .DATA_W(DW), .IMG_W(W), .IMG_H(H), .UP_SHIFT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef UB_FLUSH_EN
    .flush(flush),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int acc_count = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden nearest-neighbour up-sample of a frame whose pixels are base+i.
  task automatic push_frame(input int base);
    for (int y = 0; y < OH; y++)
      for (int x = 0; x < OW; x++)
        exp_q.push_back(16'(base + (y / F) * W + (x / F)));
  endtask

  // Called and returns just after a rising edge.
  task automatic write_pixels(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      int  t;
      bit  took;
      t = 0;
      took = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(base + i);
      while (!took) begin
        @(negedge clk);
        took = bus.in_ready;
        @(posedge clk); #1;
        t++;
        if (!took && t > TMO) begin
          chk("wr_timeout", 32'(bus.in_ready), 32'd1);
          bus.in_valid = 1'b0;
          return;
        end
      end
      acc_count++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic write_frame(input int base);
    write_pixels(base, NPIX);
    push_frame(base);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (t < TMO) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !bus.out_valid) break;
      t++;
    end
    if (t >= TMO) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // Output monitor: scoreboard pop, stall-hold check, pulse counting.
  initial begin
    logic          stall_prev;
    logic [DW-1:0] stall_data;
    logic [DW-1:0] e;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", 32'(bus.out_valid), 32'd1);
          chk("hold_data", 32'(bus.out_data), 32'(stall_data));
        end
        if (bus.wr_frame_done) wr_pulses++;
        if (bus.rd_frame_done) rd_pulses++;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("out_extra", 32'(bus.out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(e));
            n_out++;
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        stall_data = bus.out_data;
      end
    end
  end

  initial begin
    int r0, w0, s, gaps, t;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_wr_done", 32'(bus.wr_frame_done), 32'd0);
    chk("rst_rd_done", 32'(bus.rd_frame_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single frame, free-running consumer, latency after last write
    r0 = rd_pulses;
    w0 = wr_pulses;
    bus.out_ready = 1'b1;
    write_frame(0);
    @(negedge clk);
    chk("lat_before", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_after", 32'(bus.out_valid), 32'd1);
    wait_drain();
    chk("t1_rd_pulses", 32'(rd_pulses - r0), 32'd1);
    chk("t1_wr_pulses", 32'(wr_pulses - w0), 32'd1);

    // Three frames back to back with the consumer stalled
    r0 = rd_pulses;
    acc_count = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        write_frame(0);
        write_frame(16);
        write_frame(32);
      end
      begin
        t = 0;
        while (acc_count < 32 && t < TMO) begin
          @(negedge clk);
          t++;
        end
        repeat (4) @(negedge clk);
        chk("t2_in_ready_blocked", 32'(bus.in_ready), 32'd0);
        chk("t2_accepted", 32'(acc_count), 32'd32);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("t2_rd_pulses", 32'(rd_pulses - r0), 32'd3);

    // Random consumer back-pressure over two frames
    s = n_out;
    fork
      begin
        write_frame(100);
        write_frame(200);
      end
      begin
        for (int c = 0; c < 4 * TMO && n_out < s + 2 * OW * OH; c++) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();
    chk("t3_out_count", 32'(n_out - s), 32'(2 * OW * OH));

    // Writer fills frame 2 while reader drains frame 1; no bubble between frames
    s = n_out;
    r0 = rd_pulses;
    gaps = 0;
    fork
      begin
        write_frame(300);
        write_frame(400);
      end
      begin
        t = 0;
        while (n_out < s + 2 * OW * OH && t < TMO) begin
          @(negedge clk); #1;
          if (n_out > s && n_out < s + 2 * OW * OH && !bus.out_valid) gaps++;
          t++;
        end
      end
    join
    wait_drain();
    chk("t4_gaps", 32'(gaps), 32'd0);
    chk("t4_rd_pulses", 32'(rd_pulses - r0), 32'd2);

    // Reset in the middle of a frame
    write_pixels(500, 7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("t5_rst_out_valid2", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s = n_out;
    write_frame(600);
    wait_drain();
    chk("t5_out_count", 32'(n_out - s), 32'(OW * OH));

`ifdef UB_FLUSH_EN
    // Flush while the reader is mid-frame
    write_frame(700);
    s = n_out;
    t = 0;
    while (n_out < s + 10 && t < TMO) begin
      @(negedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("fl_out_valid_during", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready_during", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fl_out_valid_after", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready_after", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    s = n_out;
    write_frame(800);
    wait_drain();
    chk("fl_out_count", 32'(n_out - s), 32'(OW * OH));
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
